avalon_multi_interval_timer: RTL and testbench

Parametrised multi-channel successor to the single-channel 64-bit interval timer. Provides NUM_CH independent down-counters of CNT_W bits behind one 32-bit Avalon-MM slave. Each channel has its own 8-bit prescaler, one-shot/continuous mode, snapshot, and interrupt. Per-channel IRQs are reported on a vector and OR-reduced for the CPU interrupt line.

---
 rtl/avalon_multi_interval_timer_pkg.sv | 41 ++++
 rtl/avalon_multi_interval_timer_channel.sv | 163 ++++++++++++++++
 rtl/avalon_multi_interval_timer.sv | 82 ++++++++
 tb/tb_avalon_multi_interval_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_multi_interval_timer_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and read-word packing
// for the multi-channel interval timer.
package avalon_multi_interval_timer_pkg;

   typedef enum logic [1:0] {
      REG_STATUS  = 2'd0,
      REG_CONTROL = 2'd1,
      REG_PERIOD  = 2'd2,
      REG_SNAP    = 2'd3
   } reg_sel_e;

   localparam int CTRL_ITO    = 0;
   localparam int CTRL_CONT   = 1;
   localparam int CTRL_START  = 2;
   localparam int CTRL_STOP   = 3;
   localparam int CTRL_PS_LSB = 8;
   localparam int CTRL_PS_W   = 8;

   localparam int STAT_TO  = 0;
   localparam int STAT_RUN = 1;

   function automatic logic [31:0] status_word(input logic run_v, input logic to_v);
      logic [31:0] w;
      w           = 32'h0000_0000;
      w[STAT_RUN] = run_v;
      w[STAT_TO]  = to_v;
      return w;
   endfunction

   // START/STOP are strobes and always read back as zero
   function automatic logic [31:0] control_word(input logic ito_v, input logic cont_v,
                                                input logic [CTRL_PS_W-1:0] ps_v);
      logic [31:0] w;
      w                              = 32'h0000_0000;
      w[CTRL_ITO]                    = ito_v;
      w[CTRL_CONT]                   = cont_v;
      w[CTRL_PS_LSB +: CTRL_PS_W]    = ps_v;
      return w;
   endfunction

endpackage

// File: rtl/avalon_multi_interval_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags, CONTROL/PERIOD/SNAP
// registers. Write strobes arrive pre-decoded; register read words go out.
module avalon_multi_interval_timer_channel #(
   parameter int CNT_W        = 32,
   parameter int RESET_PERIOD = 49999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_status,
   input  logic        wr_control,
   input  logic        wr_period,
   input  logic        wr_snap,
   input  logic [31:0] writedata,
   output logic [31:0] status_rd,
   output logic [31:0] control_rd,
   output logic [31:0] period_rd,
   output logic [31:0] snap_rd,
   output logic        irq
);
   import avalon_multi_interval_timer_pkg::*;

   localparam logic [CNT_W-1:0] RST_VAL  = CNT_W'(RESET_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic             RST_ZERO = (RST_VAL == CNT_ZERO);

   logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
   logic [CNT_W-1:0]     period_r, period_nxt_s;
   logic [CNT_W-1:0]     snap_r, snap_nxt_s;
   logic [CTRL_PS_W-1:0] pscnt_r, pscnt_nxt_s;
   logic [CTRL_PS_W-1:0] ps_r, ps_nxt_s;
   logic                 run_r, run_nxt_s;
   logic                 to_r, to_nxt_s;
   logic                 ito_r, ito_nxt_s;
   logic                 cont_r, cont_nxt_s;
   logic                 zero_r, zero_nxt_s;
   logic                 reload_r, reload_nxt_s;
   logic                 irq_r, irq_nxt_s;
   logic                 start_s, stop_s, tick_s, timeout_s;
   logic                 unused_wdata_s;

   assign unused_wdata_s = ^writedata;

   // Next-state logic for counter, prescaler, flags and registers
   always_comb begin
      start_s      = wr_control && writedata[CTRL_START];
      stop_s       = wr_control && writedata[CTRL_STOP];
      tick_s       = run_r && (pscnt_r == ps_r);
      cnt_nxt_s    = cnt_r;
      pscnt_nxt_s  = pscnt_r;
      run_nxt_s    = run_r;
      to_nxt_s     = to_r;
      ito_nxt_s    = ito_r;
      cont_nxt_s   = cont_r;
      ps_nxt_s     = ps_r;
      period_nxt_s = period_r;
      snap_nxt_s   = snap_r;
      reload_nxt_s = wr_period;

      if (reload_r) begin
         cnt_nxt_s = period_r;
      end else if (tick_s) begin
         if (cnt_r == CNT_ZERO) begin
            cnt_nxt_s = period_r;
         end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end

      // zero_r mirrors (cnt_r == 0); a timeout is its rising edge
      zero_nxt_s = (cnt_nxt_s == CNT_ZERO);
      timeout_s  = zero_nxt_s && !zero_r;

      if (!run_r || start_s || reload_r || tick_s) begin
         pscnt_nxt_s = {CTRL_PS_W{1'b0}};
      end else begin
         pscnt_nxt_s = pscnt_r + {{(CTRL_PS_W-1){1'b0}}, 1'b1};
      end

      // START beats STOP and the period-write stop; one-shot stops on timeout
      if (start_s) begin
         run_nxt_s = 1'b1;
      end else if (stop_s || reload_r) begin
         run_nxt_s = 1'b0;
      end else if (timeout_s && !cont_r) begin
         run_nxt_s = 1'b0;
      end else begin
         run_nxt_s = run_r;
      end

      if (timeout_s) begin
         to_nxt_s = 1'b1;
      end else if (wr_status) begin
         to_nxt_s = 1'b0;
      end else begin
         to_nxt_s = to_r;
      end

      if (wr_control) begin
         ito_nxt_s  = writedata[CTRL_ITO];
         cont_nxt_s = writedata[CTRL_CONT];
         ps_nxt_s   = writedata[CTRL_PS_LSB +: CTRL_PS_W];
      end else begin
         ito_nxt_s  = ito_r;
         cont_nxt_s = cont_r;
         ps_nxt_s   = ps_r;
      end

      if (wr_period) begin
         period_nxt_s = writedata[CNT_W-1:0];
      end else begin
         period_nxt_s = period_r;
      end

      if (wr_snap) begin
         snap_nxt_s = cnt_r;
      end else begin
         snap_nxt_s = snap_r;
      end

      irq_nxt_s = to_nxt_s && ito_nxt_s;
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= RST_VAL;
         period_r <= RST_VAL;
         snap_r   <= CNT_ZERO;
         pscnt_r  <= {CTRL_PS_W{1'b0}};
         ps_r     <= {CTRL_PS_W{1'b0}};
         run_r    <= 1'b0;
         to_r     <= 1'b0;
         ito_r    <= 1'b0;
         cont_r   <= 1'b0;
         zero_r   <= RST_ZERO;
         reload_r <= 1'b0;
         irq_r    <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         period_r <= period_nxt_s;
         snap_r   <= snap_nxt_s;
         pscnt_r  <= pscnt_nxt_s;
         ps_r     <= ps_nxt_s;
         run_r    <= run_nxt_s;
         to_r     <= to_nxt_s;
         ito_r    <= ito_nxt_s;
         cont_r   <= cont_nxt_s;
         zero_r   <= zero_nxt_s;
         reload_r <= reload_nxt_s;
         irq_r    <= irq_nxt_s;
      end
   end

   assign status_rd  = status_word(run_r, to_r);
   assign control_rd = control_word(ito_r, cont_r, ps_r);
   assign period_rd  = 32'(period_r);
   assign snap_rd    = 32'(snap_r);
   assign irq        = irq_r;

endmodule

// File: rtl/avalon_multi_interval_timer.sv
// Multi-channel interval timer behind one 32-bit Avalon-MM slave: channel
// address decode, registered read mux and OR-reduced interrupt.
module avalon_multi_interval_timer #(
   parameter  int NUM_CH       = 4,
   parameter  int CNT_W        = 32,
   parameter  int RESET_PERIOD = 49999,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int ADDR_W       = CH_W + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              irq
);
   import avalon_multi_interval_timer_pkg::*;

   localparam int CH_SLOTS = 2 ** CH_W;

   logic            wr_s;
   logic [CH_W-1:0] ch_s;
   reg_sel_e        reg_s;
   logic [31:0]     rd_mux_s;
   logic [31:0]     rd_word_s [CH_SLOTS][4];

   assign wr_s  = chipselect && !write_n;
   assign ch_s  = address[ADDR_W-1:2];
   assign reg_s = reg_sel_e'(address[1:0]);

   // Slots past NUM_CH read as zero and never see a write strobe
   for (genvar ch = 0; ch < CH_SLOTS; ch++) begin : g_ch
      if (ch < NUM_CH) begin : g_used
         logic sel_s;
         assign sel_s = wr_s && (ch_s == CH_W'(ch));

         avalon_multi_interval_timer_channel #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
         ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_status  (sel_s && (reg_s == REG_STATUS)),
            .wr_control (sel_s && (reg_s == REG_CONTROL)),
            .wr_period  (sel_s && (reg_s == REG_PERIOD)),
            .wr_snap    (sel_s && (reg_s == REG_SNAP)),
            .writedata  (writedata),
            .status_rd  (rd_word_s[ch][0]),
            .control_rd (rd_word_s[ch][1]),
            .period_rd  (rd_word_s[ch][2]),
            .snap_rd    (rd_word_s[ch][3]),
            .irq        (irq_vec[ch])
         );
      end else begin : g_empty
         assign rd_word_s[ch][0] = 32'h0000_0000;
         assign rd_word_s[ch][1] = 32'h0000_0000;
         assign rd_word_s[ch][2] = 32'h0000_0000;
         assign rd_word_s[ch][3] = 32'h0000_0000;
      end
   end

   // Read mux on the current address, independent of chipselect
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      rd_mux_s = rd_word_s[ch_s][address[1:0]];
   end

   // Registered read data, one clock of latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'h0000_0000;
      end else begin
         readdata <= rd_mux_s;
      end
   end

   assign irq = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Directed bench: a 4-channel and a 3-channel instance share one bus so that
// out-of-range channel accesses can be compared against an in-range one.
module tb_avalon_multi_interval_timer;

   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       rd4, rd3;
   logic [3:0]        irqv4;
   logic [2:0]        irqv3;
   logic              irq4, irq3;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   avalon_multi_interval_timer #(.NUM_CH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd4),
      .irq_vec(irqv4), .irq(irq4)
   );

   avalon_multi_interval_timer #(.NUM_CH(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd3),
      .irq_vec(irqv3), .irq(irq3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_wr;
      int          ch;
      int          rg;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge
   task automatic wr(input int ch, input int rg, input logic [31:0] d);
      address    = {ch[1:0], rg[1:0]};
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input int ch, input int rg, output logic [31:0] d4, output logic [31:0] d3);
      address    = {ch[1:0], rg[1:0]};
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(negedge clk);
      d4         = rd4;
      d3         = rd3;
      chipselect = 1'b0;
   endtask

   task automatic wait_irq(input int idx, input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i <= max_cyc; i++) begin
         if (irqv4[idx]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d4, d3, s1, s2;
      int          t1, t2, c0, cs, hits;
      bit          seen;

      reset_n    = 1'b0;
      address    = 4'h0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_readdata", rd4, 32'h0);
      check("reset_irq_vec", {28'h0, irqv4}, 32'h0);
      check("reset_irq", {31'h0, irq4}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      vecs[0]  = '{1'b0, 0, 2, 32'h0,          32'd49999,    "rst_ch0_period"};
      vecs[1]  = '{1'b0, 0, 0, 32'h0,          32'h0,        "rst_ch0_status"};
      vecs[2]  = '{1'b0, 0, 1, 32'h0,          32'h0,        "rst_ch0_control"};
      vecs[3]  = '{1'b0, 0, 3, 32'h0,          32'h0,        "rst_ch0_snap"};
      vecs[4]  = '{1'b0, 3, 2, 32'h0,          32'd49999,    "rst_ch3_period"};
      vecs[5]  = '{1'b0, 2, 0, 32'h0,          32'h0,        "rst_ch2_status"};
      vecs[6]  = '{1'b1, 0, 1, 32'hFFFF_AB0B,  32'h0,        ""};
      vecs[7]  = '{1'b0, 0, 1, 32'h0,          32'h0000_AB03, "ctrl_readback"};
      vecs[8]  = '{1'b1, 0, 1, 32'h0,          32'h0,        ""};
      vecs[9]  = '{1'b0, 0, 1, 32'h0,          32'h0,        "ctrl_cleared"};
      vecs[10] = '{1'b1, 1, 2, 32'hDEAD_BEEF,  32'h0,        ""};
      vecs[11] = '{1'b0, 1, 2, 32'h0,          32'hDEAD_BEEF, "period_readback"};

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) begin
            wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
         end else begin
            rd(vecs[i].ch, vecs[i].rg, d4, d3);
            check(vecs[i].name, d4, vecs[i].exp);
         end
      end

      // Continuous, PS=1, PERIOD=9: 20 clocks between timeouts
      wr(1, 2, 32'd9);
      wr(1, 1, 32'h0000_0107);
      wait_irq(1, 30, seen);
      check("cont_first_timeout_seen", {31'h0, seen}, 32'h1);
      t1 = cyc;
      check("cont_irq_line", {31'h0, irq4}, 32'h1);
      rd(1, 0, d4, d3);
      check("cont_status_run_to", d4, 32'h3);
      wr(1, 0, 32'h0);
      check("cont_irq_vec_cleared", {28'h0, irqv4}, 32'h0);
      check("cont_irq_cleared", {31'h0, irq4}, 32'h0);
      wait_irq(1, 30, seen);
      check("cont_second_timeout_seen", {31'h0, seen}, 32'h1);
      t2 = cyc;
      check("cont_interval", t2 - t1, 32'd20);

      // STATUS write landing on the timeout edge must leave TO set
      wr(1, 0, 32'h0);
      while (cyc < t2 + 19) @(negedge clk);
      wr(1, 0, 32'h0);
      check("clear_vs_timeout_irq", {31'h0, irqv4[1]}, 32'h1);
      rd(1, 0, d4, d3);
      check("clear_vs_timeout_to", d4 & 32'h1, 32'h1);

      wr(1, 1, 32'h0000_0008);
      wr(1, 0, 32'h0);
      wr(1, 1, 32'h0000_000C);
      rd(1, 0, d4, d3);
      check("start_beats_stop", d4 & 32'h2, 32'h2);
      wr(1, 1, 32'h0000_0008);
      wr(1, 0, 32'h0);

      // One-shot, PERIOD=4
      wr(2, 2, 32'd4);
      wr(2, 1, 32'h0000_0005);
      c0 = cyc;
      wait_irq(2, 6, seen);
      check("oneshot_timeout_seen", {31'h0, seen}, 32'h1);
      rd(2, 0, d4, d3);
      check("oneshot_status_to_norun", d4, 32'h1);
      wr(2, 0, 32'h0);
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         if (irqv4[2]) hits++;
         @(negedge clk);
      end
      check("oneshot_no_second_irq", hits, 32'd0);
      wr(2, 3, 32'h0);
      rd(2, 3, d4, d3);
      check("oneshot_counter_holds_zero", d4, 32'h0);
      wr(2, 1, 32'h0000_0005);
      c0 = cyc;
      wait_irq(2, 10, seen);
      check("oneshot_restart_latency", cyc - c0, 32'd5);
      wr(2, 0, 32'h0);

      // Period write while running forces a reload and stops the channel
      wr(3, 1, 32'h0000_0004);
      repeat (3) @(negedge clk);
      rd(3, 0, d4, d3);
      check("ch3_running", d4, 32'h2);
      wr(3, 2, 32'd100);
      @(negedge clk);
      rd(3, 0, d4, d3);
      check("period_write_stops", d4, 32'h0);
      wr(3, 3, 32'h0);
      rd(3, 3, d4, d3);
      check("period_write_reloads", d4, 32'd100);

      // Two snapshots 10 clocks apart with PS=0
      wr(0, 1, 32'h0000_0006);
      repeat (5) @(negedge clk);
      wr(0, 3, 32'h0);
      cs = cyc;
      rd(0, 3, s1, d3);
      while (cyc < cs + 9) @(negedge clk);
      wr(0, 3, 32'h0);
      rd(0, 3, s2, d3);
      check("snap_delta", s1 - s2, 32'd10);

      // Channel 3 exists only in the 4-channel instance
      wr(3, 2, 32'd77);
      rd(3, 2, d4, d3);
      check("ch3_period_in_range", d4, 32'd77);
      check("ch3_period_out_of_range", d3, 32'h0);
      wr(3, 1, 32'h0000_0103);
      rd(3, 1, d4, d3);
      check("ch3_control_in_range", d4, 32'h0000_0103);
      check("ch3_control_out_of_range", d3, 32'h0);
      rd(2, 2, d4, d3);
      check("ch2_period_small_dut", d3, 32'd4);

      // Reset mid-count
      rd(0, 2, d4, d3);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset_readdata", rd4, 32'h0);
      check("midreset_irq_vec", {28'h0, irqv4}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd(0, 0, d4, d3);
      check("midreset_status", d4, 32'h0);
      rd(0, 3, d4, d3);
      check("midreset_snap", d4, 32'h0);
      rd(0, 2, d4, d3);
      check("midreset_period", d4, 32'd49999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
